// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file sequencer: register codes,
// request opcodes and FSM state encodings.
// Optional feature macro: REGSEQ_SWAP_EN (adds the SWAP op and the WR2 state).
package regfile_seq_pkg;

    localparam int         DATA_W   = 64;
    localparam logic [7:0] SEL_IDLE = 8'hFF;

    // Register codes understood by the 10-entry register file
    localparam logic [3:0] RAX = 4'd0;
    localparam logic [3:0] RBX = 4'd1;
    localparam logic [3:0] RCX = 4'd2;
    localparam logic [3:0] RDX = 4'd3;
    localparam logic [3:0] RSI = 4'd4;
    localparam logic [3:0] RDI = 4'd5;
    localparam logic [3:0] RBP = 4'd6;
    localparam logic [3:0] RSP = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;

    localparam int NUM_REGS = 10;

    // All legal codes packed into one vector, entry gi at [4*gi +: 4]
    localparam logic [4*NUM_REGS-1:0] REG_CODE_LIST =
        {R9, R8, RSP, RBP, RDI, RSI, RDX, RCX, RBX, RAX};

    typedef enum logic [1:0] {
        OP_READ2 = 2'd0,
        OP_WRITE = 2'd1,
        OP_MOVE  = 2'd2,
        OP_SWAP  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR1  = 3'd2,
`ifdef REGSEQ_SWAP_EN
        ST_WR2  = 3'd3,
`endif
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_seq_regcode_valid.sv
// Register-code checker: flags whether a 4-bit code names one of the
// ten registers of the register file.
module regcode_valid
    import regfile_seq_pkg::*;
(
    input  logic [3:0] code,
    output logic       valid
);

    logic [NUM_REGS-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_match
            assign hit[gi] = (code == REG_CODE_LIST[4*gi +: 4]);
        end
    endgenerate

    assign valid = |hit;

endmodule

// File: rtl/regfile_seq.sv
// Register-file sequencer: accepts READ2 / WRITE / MOVE / SWAP requests,
// drives the register-file port cycles and returns a registered response.
// Optional feature macro: REGSEQ_SWAP_EN (SWAP support with a WR2 cycle);
// without it op 3 is answered with an error.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int         W        = DATA_W,
    parameter logic [7:0] IDLE_SEL = SEL_IDLE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [3:0]   req_ra,
    input  logic [3:0]   req_rb,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_a,
    output logic [W-1:0] rsp_b,
    output logic         rsp_err,
    output logic [7:0]   rf_sel,
    output logic         rf_load,
    output logic [W-1:0] rf_d,
    input  logic [W-1:0] rf_a,
    input  logic [W-1:0] rf_b
);

    state_t     state_reg;
    op_t        op_reg;
    logic [3:0] rb_reg;
`ifdef REGSEQ_SWAP_EN
    logic [3:0] ra_reg;
`endif

    logic ra_ok;
    logic rb_ok;
    logic req_bad;

    regcode_valid u_ra_valid (.code(req_ra), .valid(ra_ok));
    regcode_valid u_rb_valid (.code(req_rb), .valid(rb_ok));

    // Decide whether the presented request must be rejected (bad code or unsupported op)
    always_comb begin
        req_bad = 1'b0;
        case (op_t'(req_op))
            OP_READ2: req_bad = !(ra_ok && rb_ok);
            OP_WRITE: req_bad = !rb_ok;
            OP_MOVE:  req_bad = !(ra_ok && rb_ok);
`ifdef REGSEQ_SWAP_EN
            OP_SWAP:  req_bad = !(ra_ok && rb_ok);
`else
            OP_SWAP:  req_bad = 1'b1;
`endif
            default:  req_bad = 1'b1;
        endcase
    end

    // Sequencer FSM; every output is a flop updated alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_READ2;
            rb_reg    <= '0;
`ifdef REGSEQ_SWAP_EN
            ra_reg    <= '0;
`endif
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_a     <= '0;
            rsp_b     <= '0;
            rsp_err   <= 1'b0;
            rf_sel    <= IDLE_SEL;
            rf_load   <= 1'b0;
            rf_d      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_reg    <= op_t'(req_op);
                        rb_reg    <= req_rb;
`ifdef REGSEQ_SWAP_EN
                        ra_reg    <= req_ra;
`endif
                        if (req_bad) begin
                            // Rejected: answer immediately without touching the file
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_a     <= '0;
                            rsp_b     <= '0;
                        end else if (op_t'(req_op) == OP_WRITE) begin
                            state_reg <= ST_WR1;
                            rsp_err   <= 1'b0;
                            rf_sel    <= {4'hF, req_rb};
                            rf_load   <= 1'b1;
                            rf_d      <= req_wdata;
                            rsp_a     <= req_wdata;
                            rsp_b     <= '0;
                        end else begin
                            state_reg <= ST_RD;
                            rsp_err   <= 1'b0;
                            rf_sel    <= {req_ra, req_rb};
                        end
                    end
                end
                ST_RD: begin
                    // Old A/B values double as response data and as write-back sources
                    rsp_a <= rf_a;
                    rsp_b <= rf_b;
                    if (op_reg == OP_READ2) begin
                        state_reg <= ST_RESP;
                        rf_sel    <= IDLE_SEL;
                        rsp_valid <= 1'b1;
                    end else begin
                        state_reg <= ST_WR1;
                        rf_sel    <= {4'hF, rb_reg};
                        rf_d      <= rf_a;
                        rf_load   <= 1'b1;
                    end
                end
                ST_WR1: begin
`ifdef REGSEQ_SWAP_EN
                    if (op_reg == OP_SWAP) begin
                        // Second half of the swap: old B (held in rsp_b) goes to ra
                        state_reg <= ST_WR2;
                        rf_sel    <= {4'hF, ra_reg};
                        rf_d      <= rsp_b;
                        rf_load   <= 1'b1;
                    end else
`endif
                    begin
                        state_reg <= ST_RESP;
                        rf_sel    <= IDLE_SEL;
                        rf_load   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
`ifdef REGSEQ_SWAP_EN
                ST_WR2: begin
                    state_reg <= ST_RESP;
                    rf_sel    <= IDLE_SEL;
                    rf_load   <= 1'b0;
                    rsp_valid <= 1'b1;
                end
`endif
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rf_sel    <= IDLE_SEL;
                    rf_load   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq: behavioural register file attached to
// the rf_* port, directed scenarios followed by randomized requests checked
// against an array-based reference of the register contents.
module tb_regfile_seq;
    import regfile_seq_pkg::*;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [3:0]    req_ra = 4'd0;
    logic [3:0]    req_rb = 4'd0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_a;
    logic [DW-1:0] rsp_b;
    logic          rsp_err;
    logic [7:0]    rf_sel;
    logic          rf_load;
    logic [DW-1:0] rf_d;
    logic [DW-1:0] rf_a;
    logic [DW-1:0] rf_b;

    always #5 clk = ~clk;

    regfile_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_a     (rsp_a),
        .rsp_b     (rsp_b),
        .rsp_err   (rsp_err),
        .rf_sel    (rf_sel),
        .rf_load   (rf_load),
        .rf_d      (rf_d),
        .rf_a      (rf_a),
        .rf_b      (rf_b)
    );

    // Behavioural 10 x 64 register file: combinational read, load on rising edge
    logic [DW-1:0] rf_mem [16];

    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if (rf_sel[7:4] < 4'd10) rf_a = rf_mem[rf_sel[7:4]];
        if (rf_sel[3:0] < 4'd10) rf_b = rf_mem[rf_sel[3:0]];
    end

    always @(posedge clk) begin
        if (rf_load && rf_sel[3:0] < 4'd10) rf_mem[rf_sel[3:0]] <= rf_d;
    end

    // Counts clock edges on which the register file was told to load
    int load_cnt = 0;
    always @(posedge clk) begin
        if (rf_load) load_cnt <= load_cnt + 1;
    end

    // Reference contents of the ten registers
    logic [DW-1:0] ref_regs [10];

    int checks = 0;
    int errors = 0;

`ifdef REGSEQ_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit code_ok(input logic [3:0] c);
        return c < 4'd10;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 10; i++) check_val(tag, rf_mem[i], ref_regs[i]);
    endtask

    // One complete request/response exchange, checked against the reference model
    task automatic run_txn(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [DW-1:0] wd, input int hold, input bit early);
        bit            bad;
        logic [DW-1:0] exp_a, exp_b, old_a, old_b;
        int            exp_lat, exp_wr, cyc, ld0;

        case (op)
            2'd1:    bad = !code_ok(rb);
            2'd3:    bad = !SWAP_EN || !(code_ok(ra) && code_ok(rb));
            default: bad = !(code_ok(ra) && code_ok(rb));
        endcase
        old_a = code_ok(ra) ? ref_regs[ra] : '0;
        old_b = code_ok(rb) ? ref_regs[rb] : '0;
        if (bad) begin
            exp_a = '0; exp_b = '0; exp_lat = 1; exp_wr = 0;
        end else begin
            case (op)
                2'd0: begin exp_a = old_a; exp_b = old_b; exp_lat = 2; exp_wr = 0; end
                2'd1: begin exp_a = wd; exp_b = '0; exp_lat = 2; exp_wr = 1;
                            ref_regs[rb] = wd; end
                2'd2: begin exp_a = old_a; exp_b = old_b; exp_lat = 3; exp_wr = 1;
                            ref_regs[rb] = old_a; end
                default: begin exp_a = old_a; exp_b = old_b; exp_lat = 4; exp_wr = 2;
                            ref_regs[rb] = old_a; ref_regs[ra] = old_b; end
            endcase
        end

        check_val("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb; req_wdata = wd;
        rsp_ready = early;
        ld0 = load_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("latency", cyc, exp_lat);
        check_val("rsp_a", rsp_a, exp_a);
        check_val("rsp_b", rsp_b, exp_b);
        check_val("rsp_err", rsp_err, bad);
        check_val("req_ready_busy", req_ready, 0);
        if (!early) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check_val("hold_valid", rsp_valid, 1);
                check_val("hold_a", rsp_a, exp_a);
                check_val("hold_b", rsp_b, exp_b);
                check_val("hold_err", rsp_err, bad);
                check_val("hold_ready", req_ready, 0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val("rsp_done", rsp_valid, 0);
        check_val("req_ready_back", req_ready, 1);
        check_val("load_pulses", load_cnt - ld0, exp_wr);
        check_val("rf_sel_idle", rf_sel, 8'hFF);
        check_regs("reg");
        $display("txn op=%0d ra=%0d rb=%0d a=%h b=%h err=%0b lat=%0d", op, ra, rb, rsp_a, rsp_b,
                 rsp_err, cyc);
    endtask

    // Reset asserted while the sequencer is driving a write cycle
    task automatic reset_mid(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb);
        int cyc;
        req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!rf_load && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("mid_load_seen", rf_load, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_load", rf_load, 0);
        check_val("mid_rst_sel", rf_sel, 8'hFF);
        check_val("mid_rst_valid", rsp_valid, 0);
        check_val("mid_rst_ready", req_ready, 1);
        check_val("mid_rst_a", rsp_a, 0);
        check_val("mid_rst_b", rsp_b, 0);
        check_val("mid_rst_d", rf_d, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // The pending load was withdrawn before any edge sampled it
        check_regs("mid_rst_reg");
        $display("txn reset during op=%0d ra=%0d rb=%0d", op, ra, rb);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]    op;
        logic [3:0]    ra, rb;
        logic [DW-1:0] wd;

        for (int i = 0; i < 10; i++) ref_regs[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_a", rsp_a, 0);
        check_val("rst_rsp_b", rsp_b, 0);
        check_val("rst_rsp_err", rsp_err, 0);
        check_val("rst_rf_sel", rf_sel, 8'hFF);
        check_val("rst_rf_load", rf_load, 0);
        check_val("rst_rf_d", rf_d, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Initialise every register through the sequencer
        for (int i = 0; i < 10; i++)
            run_txn(2'd1, 4'd0, 4'(i), {$urandom, $urandom}, 0, 1'b0);

        // Directed scenarios
        run_txn(2'd1, 4'd0, RAX, 64'h1122_3344_5566_7788, 0, 1'b0);
        run_txn(2'd0, RAX, RAX, '0, 0, 1'b0);
        run_txn(2'd1, 4'd0, RDI, 64'd5, 0, 1'b1);
        run_txn(2'd1, 4'd0, RSI, 64'd9, 0, 1'b0);
        run_txn(2'd2, RDI, RSI, '0, 0, 1'b0);
        run_txn(2'd0, RSI, RDI, '0, 0, 1'b0);
        run_txn(2'd1, 4'd0, R8, 64'd1, 0, 1'b0);
        run_txn(2'd1, 4'd0, R9, 64'd2, 0, 1'b0);
        run_txn(2'd3, R8, R9, '0, 0, 1'b0);
        run_txn(2'd0, R8, R9, '0, 0, 1'b0);
        run_txn(2'd3, RCX, RCX, '0, 0, 1'b0);
        run_txn(2'd2, RBX, RBX, '0, 0, 1'b1);
        run_txn(2'd0, 4'hF, RAX, '0, 0, 1'b0);
        run_txn(2'd1, RAX, 4'hA, 64'hDEAD, 0, 1'b0);
        run_txn(2'd0, RDX, RBP, '0, 5, 1'b0);
        run_txn(2'd2, RSP, RDX, '0, 5, 1'b0);

        reset_mid(SWAP_EN ? 2'd3 : 2'd2, R8, R9);

        // Randomized requests, mostly legal codes with occasional bad ones
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 11));
            rb = 4'($urandom_range(0, 11));
            wd = {$urandom, $urandom};
            run_txn(op, ra, rb, wd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
